// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipeline-register slice: bubble instruction,
// handshake state codes and the {pc, instr} entry layout.
package pipe_stage_reg_pkg;

  localparam int unsigned PIPE_PC_W    = 32;
  localparam int unsigned PIPE_INSTR_W = 32;

  localparam logic [31:0] PIPE_NOP = 32'h0000_0000;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  typedef struct packed {
    logic [PIPE_PC_W-1:0]    pc;
    logic [PIPE_INSTR_W-1:0] instr;
  } entry_t;

endpackage

// File: rtl/pipe_stage_reg_entry.sv
// One stored pipeline entry with load and clear-to-bubble controls;
// clear wins over load.
module pipe_entry_reg #(
  parameter int unsigned   W       = 64,
  parameter logic [W-1:0] CLR_VAL = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_r;

  // Entry storage: reset/clear load the bubble value, otherwise capture on load.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      q_r <= CLR_VAL;
    end else if (load) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: valid/ready handshake, optional one-entry
// skid, synchronous flush and a saturating back-pressure cycle counter.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned         PC_W      = 32,
  parameter int unsigned         INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(PIPE_NOP),
  parameter int unsigned         SKID      = 1,
  parameter int unsigned         CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam int unsigned         ENTRY_W     = PC_W + INSTR_W;
  localparam logic [ENTRY_W-1:0] EMPTY_ENTRY = {{PC_W{1'b0}}, NOP_INSTR};
  localparam logic [CNT_W-1:0]   CNT_MAX     = {CNT_W{1'b1}};
  localparam bit                  SKID_EN     = (SKID != 32'd0);

  logic [1:0]         state_r;
  logic [1:0]         state_nxt_s;
  logic               in_xfer_s;
  logic               out_xfer_s;
  logic               main_load_s;
  logic               main_clr_s;
  logic               main_from_skid_s;
  logic               skid_load_s;
  logic               skid_clr_s;
  logic [ENTRY_W-1:0] in_entry_s;
  logic [ENTRY_W-1:0] main_d_s;
  logic [ENTRY_W-1:0] main_q_s;
  logic [ENTRY_W-1:0] skid_q_s;
  logic [CNT_W-1:0]   stall_cnt_r;

  assign in_entry_s = {in_pc, in_instr};
  assign in_xfer_s  = in_valid && in_ready;
  assign out_xfer_s = out_valid && out_ready;
  assign out_valid  = (state_r != ST_EMPTY);

  // With a skid entry, in_ready is a pure state decode; without it the
  // stage can only accept when the held entry is leaving this cycle.
  generate
    if (SKID_EN) begin : g_ready_skid
      assign in_ready = (state_r != ST_FULL);
    end else begin : g_ready_single
      assign in_ready = (state_r == ST_EMPTY) || out_ready;
    end
  endgenerate

  // Next-state and entry-register controls; flush overrides all transfers.
  always_comb begin
    state_nxt_s      = state_r;
    main_load_s      = 1'b0;
    main_clr_s       = 1'b0;
    main_from_skid_s = 1'b0;
    skid_load_s      = 1'b0;
    skid_clr_s       = 1'b0;
    if (flush) begin
      state_nxt_s = ST_EMPTY;
      main_clr_s  = 1'b1;
      skid_clr_s  = 1'b1;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_xfer_s) begin
            main_load_s = 1'b1;
            state_nxt_s = ST_ONE;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_xfer_s && out_xfer_s) begin
            main_load_s = 1'b1;
          end else if (out_xfer_s) begin
            main_clr_s  = 1'b1;
            state_nxt_s = ST_EMPTY;
          end else if (in_xfer_s && SKID_EN) begin
            skid_load_s = 1'b1;
            state_nxt_s = ST_FULL;
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
        ST_FULL: begin
          if (out_xfer_s) begin
            main_load_s      = 1'b1;
            main_from_skid_s = 1'b1;
            skid_clr_s       = 1'b1;
            state_nxt_s      = ST_ONE;
          end else begin
            state_nxt_s = ST_FULL;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
          main_clr_s  = 1'b1;
          skid_clr_s  = 1'b1;
        end
      endcase
    end
  end

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  assign main_d_s = main_from_skid_s ? skid_q_s : in_entry_s;

  pipe_entry_reg #(
    .W       (ENTRY_W),
    .CLR_VAL (EMPTY_ENTRY)
  ) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load_s),
    .clear (main_clr_s),
    .d     (main_d_s),
    .q     (main_q_s)
  );

  generate
    if (SKID_EN) begin : g_skid
      pipe_entry_reg #(
        .W       (ENTRY_W),
        .CLR_VAL (EMPTY_ENTRY)
      ) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load_s),
        .clear (skid_clr_s),
        .d     (in_entry_s),
        .q     (skid_q_s)
      );
    end else begin : g_no_skid
      assign skid_q_s = EMPTY_ENTRY;
    end
  endgenerate

  assign out_pc    = main_q_s[ENTRY_W-1 -: PC_W];
  assign out_instr = main_q_s[INSTR_W-1:0];

  // Stall counter: cycles where a held entry is refused downstream; flush
  // leaves it alone and it sticks at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (out_valid && !out_ready && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: skid, single-entry and 3-bit-counter instances
// against a queue-based reference model.
module tb_pipe_stage_reg;
  import pipe_stage_reg_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_pc, in_instr;

  logic        ir1, ov1, ir0, ov0, irs, ovs;
  logic [31:0] pc1, in1, pc0, in0, pcs, ins;
  logic [15:0] sc1, sc0;
  logic [2:0]  scs;

  int n_chk = 0;
  int n_err = 0;

  entry_t q1[$];
  entry_t q0[$];
  int cnt1, cnt0, cnts;

  always #5 clk = ~clk;

  pipe_stage_reg #(.NOP_INSTR(NOP), .SKID(1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
    .in_pc(in_pc), .in_instr(in_instr), .out_valid(ov1), .out_ready(out_ready),
    .out_pc(pc1), .out_instr(in1), .stall_cnt(sc1));

  pipe_stage_reg #(.NOP_INSTR(NOP), .SKID(0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
    .in_pc(in_pc), .in_instr(in_instr), .out_valid(ov0), .out_ready(out_ready),
    .out_pc(pc0), .out_instr(in0), .stall_cnt(sc0));

  pipe_stage_reg #(.NOP_INSTR(NOP), .SKID(1), .CNT_W(3)) dut_s (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(irs),
    .in_pc(in_pc), .in_instr(in_instr), .out_valid(ovs), .out_ready(out_ready),
    .out_pc(pcs), .out_instr(ins), .stall_cnt(scs));

  // Advance one clock and update the reference FIFO models (no checking here).
  task automatic step();
    entry_t e;
    bit r1, r0;
    e.pc = in_pc;
    e.instr = in_instr;
    @(posedge clk);
    if (reset) begin
      q1.delete(); q0.delete(); cnt1 = 0; cnt0 = 0; cnts = 0;
    end else begin
      if (q1.size() > 0 && !out_ready) begin
        if (cnt1 < 65535) cnt1++;
        if (cnts < 7) cnts++;
      end
      if (q0.size() > 0 && !out_ready && cnt0 < 65535) cnt0++;
      if (flush) begin
        q1.delete(); q0.delete();
      end else begin
        r1 = (q1.size() < 2);
        r0 = (q0.size() == 0) || out_ready;
        if (q1.size() > 0 && out_ready) void'(q1.pop_front());
        if (in_valid && r1) q1.push_back(e);
        if (q0.size() > 0 && out_ready) void'(q0.pop_front());
        if (in_valid && r0) q0.push_back(e);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = 32'h0; in_instr = 32'h0;
    step(); step();
    reset = 1'b0;
    #1;
    n_chk++; if (ov1 !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%0h exp=0", ov1); end
    n_chk++; if (pc1 !== 32'h0) begin n_err++; $display("FAIL reset_pc got=%0h exp=0", pc1); end
    n_chk++; if (in1 !== NOP) begin n_err++; $display("FAIL reset_instr got=%0h exp=%0h", in1, NOP); end
    n_chk++; if (sc1 !== 16'd0) begin n_err++; $display("FAIL reset_stall got=%0d exp=0", sc1); end
    n_chk++; if (ir1 !== 1'b1) begin n_err++; $display("FAIL reset_in_ready_skid got=%0h exp=1", ir1); end
    n_chk++; if (ir0 !== 1'b1) begin n_err++; $display("FAIL reset_in_ready_noskid got=%0h exp=1", ir0); end
    n_chk++; if (ov0 !== 1'b0 || in0 !== NOP) begin n_err++; $display("FAIL reset_noskid got=%0h/%0h exp=0/%0h", ov0, in0, NOP); end
    n_chk++; if (scs !== 3'd0) begin n_err++; $display("FAIL reset_stall_sat got=%0d exp=0", scs); end
  endtask

  task automatic test_streaming();
    logic [31:0] ins_v [3];
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = 32'h3000 + 32'(i * 4); in_instr = $urandom; ins_v[i] = in_instr;
      step();
      n_chk++; if (ov1 !== 1'b1 || pc1 !== in_pc || in1 !== ins_v[i]) begin
        n_err++; $display("FAIL stream_skid[%0d] got=%0h/%0h/%0h exp=1/%0h/%0h", i, ov1, pc1, in1, in_pc, ins_v[i]); end
      n_chk++; if (ov0 !== 1'b1 || pc0 !== in_pc) begin
        n_err++; $display("FAIL stream_noskid[%0d] got=%0h/%0h exp=1/%0h", i, ov0, pc0, in_pc); end
    end
    in_valid = 1'b0;
    step();
    n_chk++; if (ov1 !== 1'b0 || in1 !== NOP || pc1 !== 32'h0) begin
      n_err++; $display("FAIL stream_drain got=%0h/%0h/%0h exp=0/0/%0h", ov1, pc1, in1, NOP); end
  endtask

  task automatic test_skid_fill();
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h3000; in_instr = $urandom;
    step();
    n_chk++; if (ir1 !== 1'b1 || pc1 !== 32'h3000 || sc1 !== 16'd0) begin
      n_err++; $display("FAIL skid_first got=%0h/%0h/%0d exp=1/3000/0", ir1, pc1, sc1); end
    in_pc = 32'h3004; in_instr = $urandom;
    step();
    n_chk++; if (ir1 !== 1'b0 || pc1 !== 32'h3000 || sc1 !== 16'd1) begin
      n_err++; $display("FAIL skid_full got=%0h/%0h/%0d exp=0/3000/1", ir1, pc1, sc1); end
    in_valid = 1'b0;
    step();
    n_chk++; if (sc1 !== 16'd2 || ov1 !== 1'b1) begin
      n_err++; $display("FAIL skid_stall2 got=%0d/%0h exp=2/1", sc1, ov1); end
    out_ready = 1'b1;
    step();
    n_chk++; if (ov1 !== 1'b1 || pc1 !== 32'h3004 || ir1 !== 1'b1) begin
      n_err++; $display("FAIL skid_drain1 got=%0h/%0h/%0h exp=1/3004/1", ov1, pc1, ir1); end
    step();
    n_chk++; if (ov1 !== 1'b0 || ir1 !== 1'b1) begin
      n_err++; $display("FAIL skid_drain2 got=%0h/%0h exp=0/1", ov1, ir1); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h3020; in_instr = $urandom;
    step();
    in_pc = 32'h3024;
    step();
    n_chk++; if (ir1 !== 1'b0 || sc1 !== 16'd3) begin
      n_err++; $display("FAIL flush_prefill got=%0h/%0d exp=0/3", ir1, sc1); end
    flush = 1'b1; out_ready = 1'b1; in_pc = 32'h3010;
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_chk++; if (ov1 !== 1'b0 || in1 !== NOP || pc1 !== 32'h0 || sc1 !== 16'd3) begin
      n_err++; $display("FAIL flush_state got=%0h/%0h/%0h/%0d exp=0/0/%0h/3", ov1, pc1, in1, sc1, NOP); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++; if (ov1 !== 1'b0 || pc1 === 32'h3010) begin
        n_err++; $display("FAIL flush_dropped[%0d] got=%0h/%0h exp=0/not3010", i, ov1, pc1); end
    end
  endtask

  task automatic test_noskid_backpressure();
    out_ready = 1'b1; in_valid = 1'b1; in_pc = 32'h4000; in_instr = $urandom;
    step();
    out_ready = 1'b0; in_pc = 32'h4004;
    #1;
    n_chk++; if (ir0 !== 1'b0) begin n_err++; $display("FAIL bp_ready_drop got=%0h exp=0", ir0); end
    step(); step();
    n_chk++; if (ov0 !== 1'b1 || pc0 !== 32'h4000) begin
      n_err++; $display("FAIL bp_hold got=%0h/%0h exp=1/4000", ov0, pc0); end
    out_ready = 1'b1;
    #1;
    n_chk++; if (ir0 !== 1'b1) begin n_err++; $display("FAIL bp_ready_rise got=%0h exp=1", ir0); end
    step();
    n_chk++; if (ov0 !== 1'b1 || pc0 !== 32'h4004) begin
      n_err++; $display("FAIL bp_next got=%0h/%0h exp=1/4004", ov0, pc0); end
    in_valid = 1'b0;
    step(); step();
    n_chk++; if (ov0 !== 1'b0 || in0 !== NOP) begin
      n_err++; $display("FAIL bp_empty got=%0h/%0h exp=0/%0h", ov0, in0, NOP); end
  endtask

  task automatic test_saturation();
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h5000; in_instr = $urandom;
    step();
    in_valid = 1'b0;
    repeat (10) step();
    n_chk++; if (scs !== 3'd7) begin n_err++; $display("FAIL sat_cnt got=%0d exp=7", scs); end
    n_chk++; if (sc1 !== 16'(cnt1)) begin n_err++; $display("FAIL sat_wide got=%0d exp=%0d", sc1, cnt1); end
    out_ready = 1'b1;
    step(); step();
    n_chk++; if (scs !== 3'd7 || ovs !== 1'b0) begin
      n_err++; $display("FAIL sat_hold got=%0d/%0h exp=7/0", scs, ovs); end
  endtask

  task automatic test_random();
    bit ev;
    for (int c = 0; c < 400; c++) begin
      reset     = ($urandom_range(127) == 0);
      flush     = ($urandom_range(15) == 0);
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      in_pc     = $urandom;
      in_instr  = $urandom;
      step();
      ev = (q1.size() > 0);
      n_chk++; if (ov1 !== ev || pc1 !== (ev ? q1[0].pc : 32'h0) || in1 !== (ev ? q1[0].instr : NOP)) begin
        n_err++; $display("FAIL rand_skid_out c=%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h", c, ov1, pc1, in1,
          ev, ev ? q1[0].pc : 32'h0, ev ? q1[0].instr : NOP); end
      n_chk++; if (ir1 !== (q1.size() < 2) || sc1 !== 16'(cnt1)) begin
        n_err++; $display("FAIL rand_skid_ctl c=%0d got=%0h/%0d exp=%0h/%0d", c, ir1, sc1, q1.size() < 2, cnt1); end
      n_chk++; if (ovs !== ev || pcs !== (ev ? q1[0].pc : 32'h0) || scs !== 3'(cnts) || irs !== (q1.size() < 2)) begin
        n_err++; $display("FAIL rand_sat c=%0d got=%0h/%0h/%0d exp=%0h/%0d", c, ovs, pcs, scs, ev, cnts); end
      ev = (q0.size() > 0);
      n_chk++; if (ov0 !== ev || pc0 !== (ev ? q0[0].pc : 32'h0) || in0 !== (ev ? q0[0].instr : NOP)) begin
        n_err++; $display("FAIL rand_noskid_out c=%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h", c, ov0, pc0, in0,
          ev, ev ? q0[0].pc : 32'h0, ev ? q0[0].instr : NOP); end
      n_chk++; if (ir0 !== (!ev || out_ready) || sc0 !== 16'(cnt0)) begin
        n_err++; $display("FAIL rand_noskid_ctl c=%0d got=%0h/%0d exp=%0h/%0d", c, ir0, sc0, !ev || out_ready, cnt0); end
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_skid_fill();
    test_flush();
    test_noskid_backpressure();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
